move_sequencer: RTL
===================

MOVE_SEQUENCER -- requirements
Module: move_sequencer

Interface
REQ-001 The block SHALL provide parameter STEP_PX, default 16, giving the pixels moved per tile step.
REQ-002 The block SHALL provide parameter TURN_TICKS, default 4, giving the frame ticks spent in a turn-in-place.
REQ-003 The block SHALL provide parameters X_MAX (default 640) and Y_MAX (default 480), giving the camera limits, inclusive.
REQ-004 The block SHALL provide parameters START_X and START_Y, default 96 each, giving the camera position after reset.
REQ-005 Clk  input  1  system clock; the only clock in the block.
REQ-006 Reset  input  1  reset, synchronous, active-high.
REQ-007 VS  input  1  raw VGA vertical sync, sampled on Clk.
REQ-008 Character_Moving  input  1  a direction key is held.
REQ-009 Direction  input  2  requested direction: 0 UP, 1 RIGHT, 2 DOWN, 3 LEFT.
REQ-010 Blocked  input  1  the tile adjacent in the facing direction is impassable.
REQ-011 topleftX, topleftY  output  11 each  camera offset for the map and sprite renderer.
REQ-012 Facing  output  2  current facing direction, same encoding as Direction.
REQ-013 Frame  output  2  animation frame: 0 REST1, 1 M1, 2 REST2, 3 M2.
REQ-014 Walking  output  1  high while in state WALK.
REQ-015 Step_Done  output  1  one-Clk pulse when a tile step completes.

Function
REQ-016 The tick SHALL be a one-cycle pulse on each VS 0->1 transition, detected from a registered copy of VS; all FSM activity SHALL occur only on tick cycles.
REQ-017 The FSM SHALL have three states: IDLE, TURN and WALK.
REQ-018 IDLE, on tick, when Character_Moving=1 and Direction!=Facing: Facing<=Direction; go to TURN; clear the tick counter.
REQ-019 IDLE, on tick, when Character_Moving=1 and Direction==Facing and the step is legal: go to WALK; set counter=0; move 1 px.
REQ-020 A step SHALL be legal only when Blocked=0 and the move stays inside the limits: UP needs topleftY>=STEP_PX; DOWN needs topleftY+STEP_PX<=Y_MAX; LEFT needs topleftX>=STEP_PX; RIGHT needs topleftX+STEP_PX<=X_MAX.
REQ-021 A step that is not legal SHALL leave the FSM in IDLE with no movement.
REQ-022 TURN SHALL return to IDLE after TURN_TICKS ticks, ignoring all inputs.
REQ-023 WALK SHALL move 1 px per tick in the Facing direction (UP: Y-1, DOWN: Y+1, LEFT: X-1, RIGHT: X+1) and increment the counter.
REQ-024 On the tick where the counter reaches STEP_PX-1, WALK SHALL pulse Step_Done and toggle the parity bit.
REQ-025 On that same tick, WALK SHALL restart with counter=0 if Character_Moving=1, Direction==Facing and the next step is legal; otherwise it SHALL go to IDLE.
REQ-026 Direction and Blocked changes mid-step SHALL be ignored; every step SHALL complete its full STEP_PX pixels.
REQ-027 Frame in IDLE and TURN SHALL be REST1.
REQ-028 Frame in WALK SHALL be M1 (parity 0) or M2 (parity 1) for counter 0..STEP_PX/2-1, and REST2 (parity 0) or REST1 (parity 1) for the remaining counts.
REQ-029 Outputs SHALL be registered; a position change SHALL become visible on the Clk edge that ends the tick cycle.
REQ-030 topleftX and topleftY SHALL never go below 0 or above X_MAX / Y_MAX, and SHALL stay multiples of STEP_PX whenever the FSM is in IDLE.

Reset
REQ-031 Reset SHALL override any tick in the same cycle, including a reset arriving mid-step.
REQ-032 Reset values: state IDLE; topleftX=START_X; topleftY=START_Y; Facing=DOWN; Frame=REST1; Walking=0; Step_Done=0; counter=0; parity=0.
REQ-033 Reset SHALL set the VS history register to 1 so that no tick is generated on the first cycle after reset.

Structure
REQ-034 Shared package pokemon_pkg SHALL hold dir_t (UP, RIGHT, DOWN, LEFT = 0..3) and anim_frame_t (REST1, M1, REST2, M2 = 0..3).
REQ-035 The color mapper SHALL consume these same types from pokemon_pkg.
REQ-036 The VS edge detector SHALL be the sub-module frame_tick (ports Clk, Reset, VS, tick).
REQ-037 The FSM, counters and position registers SHALL stay in move_sequencer itself.

Verification
REQ-038 Reset, Facing=DOWN, hold Direction=2 with Moving=1 for 16 ticks -> topleftY goes 96->112; Step_Done pulses exactly once; Frame shows M1 for 8 ticks then REST2.
REQ-039 From IDLE facing DOWN, press RIGHT -> TURN for 4 ticks with topleftX unchanged; Facing=1; walking starts on the next tick.
REQ-040 Hold UP continuously for 32 ticks -> two steps; frames M1, REST2, M2, REST1; topleftY 96->64; Walking stays high throughout.
REQ-041 Blocked=1 while facing LEFT, or topleftX=0 with LEFT held -> no movement; state stays IDLE.
REQ-042 Assert Reset at counter=7 mid-step -> the next cycle shows 96/96, IDLE, REST1, and no Step_Done pulse.
REQ-043 Flip Direction to LEFT during a DOWN step -> the DOWN step completes to +16 px, then the block turns to LEFT.

Source files
------------

// File: rtl/pokemon_pkg.sv
// Shared types for the overworld movement and rendering path.
package pokemon_pkg;

   typedef enum logic [1:0] {
      UP    = 2'd0,
      RIGHT = 2'd1,
      DOWN  = 2'd2,
      LEFT  = 2'd3
   } dir_t;

   typedef enum logic [1:0] {
      REST1 = 2'd0,
      M1    = 2'd1,
      REST2 = 2'd2,
      M2    = 2'd3
   } anim_frame_t;

   typedef enum logic [1:0] {
      MV_IDLE = 2'd0,
      MV_TURN = 2'd1,
      MV_WALK = 2'd2
   } mv_state_t;

   // Walking sprite frame: a stride pose in the first half of a step, a rest
   // pose in the second half, alternating legs on every other step.
   function automatic anim_frame_t walk_frame(input logic first_half, input logic parity);
      if (first_half)
         return parity ? M2 : M1;
      else
         return parity ? REST1 : REST2;
   endfunction

endpackage

// File: rtl/move_sequencer_frame_tick.sv
// Turns the raw VGA vertical sync into a one-cycle frame tick on each rising edge.
module frame_tick (
   input  logic Clk,
   input  logic Reset,
   input  logic VS,
   output logic tick
);

   logic vs_q;

   // Keep last cycle's VS; reset to 1 so no edge is seen right after reset.
   always_ff @(posedge Clk) begin
      if (Reset)
         vs_q <= 1'b1;
      else
         vs_q <= VS;
   end

   assign tick = VS & ~vs_q;

endmodule

// File: rtl/move_sequencer.sv
// Tile-stepped camera movement with turn-in-place and walk animation.
module move_sequencer
   import pokemon_pkg::*;
#(
   parameter int STEP_PX    = 16,
   parameter int TURN_TICKS = 4,
   parameter int X_MAX      = 640,
   parameter int Y_MAX      = 480,
   parameter int START_X    = 96,
   parameter int START_Y    = 96
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        VS,
   input  logic        Character_Moving,
   input  logic [1:0]  Direction,
   input  logic        Blocked,
   output logic [10:0] topleftX,
   output logic [10:0] topleftY,
   output logic [1:0]  Facing,
   output logic [1:0]  Frame,
   output logic        Walking,
   output logic        Step_Done
);

   localparam int CNT_MAX = (STEP_PX > TURN_TICKS) ? STEP_PX : TURN_TICKS;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_PX - 1);
   localparam logic [CNT_W-1:0] HALF_STEP = CNT_W'(STEP_PX / 2);
   localparam logic [CNT_W-1:0] TURN_LAST = CNT_W'(TURN_TICKS - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   localparam logic [11:0] STEP_EXT  = 12'(STEP_PX);
   localparam logic [11:0] X_MAX_EXT = 12'(X_MAX);
   localparam logic [11:0] Y_MAX_EXT = 12'(Y_MAX);

   logic              tick;
   mv_state_t         state, state_n;
   logic [CNT_W-1:0]  counter, counter_n;
   logic              parity, parity_n;
   dir_t              facing, facing_n;
   logic [10:0]       pos_x, pos_y, pos_x_n, pos_y_n;
   logic [10:0]       moved_x, moved_y;
   logic [11:0]       x_ext, y_ext;
   logic              step_legal;
   anim_frame_t       frame_q, frame_n;
   logic              walking_q, walking_n;
   logic              done_q, done_n;

   frame_tick u_frame_tick (
      .Clk   (Clk),
      .Reset (Reset),
      .VS    (VS),
      .tick  (tick)
   );

   assign x_ext = {1'b0, pos_x};
   assign y_ext = {1'b0, pos_y};

   // A new step is allowed only onto a passable tile that keeps the camera in bounds.
   always_comb begin
      step_legal = 1'b0;
      unique case (facing)
         UP:    step_legal = (y_ext >= STEP_EXT);
         DOWN:  step_legal = ((y_ext + STEP_EXT) <= Y_MAX_EXT);
         LEFT:  step_legal = (x_ext >= STEP_EXT);
         RIGHT: step_legal = ((x_ext + STEP_EXT) <= X_MAX_EXT);
      endcase
      if (Blocked)
         step_legal = 1'b0;
   end

   // Position one pixel further along the facing direction.
   always_comb begin
      moved_x = pos_x;
      moved_y = pos_y;
      unique case (facing)
         UP:    moved_y = pos_y - 11'd1;
         DOWN:  moved_y = pos_y + 11'd1;
         LEFT:  moved_x = pos_x - 11'd1;
         RIGHT: moved_x = pos_x + 11'd1;
      endcase
   end

   // Next-state logic: everything advances only on frame ticks.
   always_comb begin
      state_n   = state;
      counter_n = counter;
      parity_n  = parity;
      facing_n  = facing;
      pos_x_n   = pos_x;
      pos_y_n   = pos_y;
      done_n    = 1'b0;

      if (tick) begin
         unique case (state)
            MV_IDLE: begin
               if (Character_Moving) begin
                  if (dir_t'(Direction) != facing) begin
                     facing_n  = dir_t'(Direction);
                     state_n   = MV_TURN;
                     counter_n = '0;
                  end else if (step_legal) begin
                     state_n   = MV_WALK;
                     counter_n = '0;
                     pos_x_n   = moved_x;
                     pos_y_n   = moved_y;
                  end
               end
            end
            MV_TURN: begin
               if (counter == TURN_LAST) begin
                  state_n   = MV_IDLE;
                  counter_n = '0;
               end else begin
                  counter_n = counter + CNT_ONE;
               end
            end
            MV_WALK: begin
               if (counter == STEP_LAST) begin
                  done_n    = 1'b1;
                  parity_n  = ~parity;
                  counter_n = '0;
                  if (Character_Moving && (dir_t'(Direction) == facing) && step_legal) begin
                     pos_x_n = moved_x;
                     pos_y_n = moved_y;
                  end else begin
                     state_n = MV_IDLE;
                  end
               end else begin
                  counter_n = counter + CNT_ONE;
                  pos_x_n   = moved_x;
                  pos_y_n   = moved_y;
               end
            end
            default: begin
               state_n   = MV_IDLE;
               counter_n = '0;
            end
         endcase
      end

      walking_n = (state_n == MV_WALK);
      if (state_n == MV_WALK)
         frame_n = walk_frame(counter_n < HALF_STEP, parity_n);
      else
         frame_n = REST1;
   end

   // State, position and output registers; reset wins over a same-cycle tick.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state     <= MV_IDLE;
         counter   <= '0;
         parity    <= 1'b0;
         facing    <= DOWN;
         pos_x     <= 11'(START_X);
         pos_y     <= 11'(START_Y);
         frame_q   <= REST1;
         walking_q <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state     <= state_n;
         counter   <= counter_n;
         parity    <= parity_n;
         facing    <= facing_n;
         pos_x     <= pos_x_n;
         pos_y     <= pos_y_n;
         frame_q   <= frame_n;
         walking_q <= walking_n;
         done_q    <= done_n;
      end
   end

   assign topleftX  = pos_x;
   assign topleftY  = pos_y;
   assign Facing    = facing;
   assign Frame     = frame_q;
   assign Walking   = walking_q;
   assign Step_Done = done_q;

endmodule
